// File: rtl/cal_strobe_seq_if.sv
// Request/configuration inputs and strobe/status outputs of cal_strobe_seq.
// The master side drives requests and settings; the slave side is the sequencer.
interface cal_strobe_seq_if #(
   parameter int DELAY_W = 6,
   parameter int WIDTH_W = 4
) ();
   logic               calReq;
   logic               dtpReq;
   logic               enable;
   logic [DELAY_W-1:0] delay;
   logic [WIDTH_W-1:0] width;
   logic               calPolarity;
   logic               calStrobe;
   logic               dtpStrobe;
   logic               busy;
   logic               done;
   logic [3:0]         missed;

   modport master (output calReq, dtpReq, enable, delay, width, calPolarity,
                   input  calStrobe, dtpStrobe, busy, done, missed);
   modport slave  (input  calReq, dtpReq, enable, delay, width, calPolarity,
                   output calStrobe, dtpStrobe, busy, done, missed);
endinterface

// File: rtl/cal_strobe_seq.sv
// Calibration / digital-test strobe sequencer: delayed, width-programmable strobe with hold-off.
// Optional macro CAL_POLARITY_EN enables the selectable calStrobe polarity.
module cal_strobe_seq #(
   parameter int DELAY_W = 6,
   parameter int WIDTH_W = 4,
   parameter int HOLDOFF = 4
) (
   input  logic            bclka,
   input  logic            rstb,
   cal_strobe_seq_if.slave bus
);
   localparam int HOLD_W = $clog2(HOLDOFF + 1);
   localparam int CNT_W0 = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
   localparam int CNT_W  = (CNT_W0 > HOLD_W) ? CNT_W0 : HOLD_W;

   typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_PULSE, ST_HOLDOFF} stateT;

   stateT              stateReg, stateNext;
   logic [CNT_W-1:0]   cntReg, cntNext;
   logic               isCalReg, isCalNext;
   logic [WIDTH_W-1:0] widthM1Reg, widthM1Next;
   logic [WIDTH_W-1:0] widthM1In;
   logic [1:0]         reqVec, reqDReg, reqRise;
   logic               calStrobeReg, calStrobeNext;
   logic               dtpStrobeReg, dtpStrobeNext;
   logic               doneReg, doneNext;
   logic [3:0]         missedReg, missedNext;
   logic [1:0]         missInc;
   logic [4:0]         missSum;
   logic               pulseNext;
   logic               calIdleLevel;

`ifdef CAL_POLARITY_EN
   assign calIdleLevel = ~bus.calPolarity;
`else
   logic unusedCalPolarity;
   assign unusedCalPolarity = bus.calPolarity;
   assign calIdleLevel      = 1'b0;
`endif

   // Bit 0 is the calibration request, bit 1 the digital-test request.
   assign reqVec = {bus.dtpReq, bus.calReq};
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gRise
         assign reqRise[gi] = reqVec[gi] & ~reqDReg[gi];
      end
   endgenerate

   // A programmed width of 0 behaves like 1, so store width-1 clamped at 0.
   assign widthM1In = (bus.width == '0) ? '0 : bus.width - WIDTH_W'(1);

   always_comb begin
      stateNext   = stateReg;
      cntNext     = cntReg;
      isCalNext   = isCalReg;
      widthM1Next = widthM1Reg;
      doneNext    = 1'b0;
      missInc     = 2'd0;
      if (!bus.enable) begin
         stateNext = ST_IDLE;
         cntNext   = '0;
      end else begin
         if (stateReg != ST_IDLE) begin
            missInc = {1'b0, reqRise[0]} + {1'b0, reqRise[1]};
         end
         case (stateReg)
            ST_IDLE: begin
               if (reqRise != 2'b00) begin
                  isCalNext   = reqRise[0];
                  widthM1Next = widthM1In;
                  missInc     = {1'b0, &reqRise};
                  if (bus.delay != '0) begin
                     stateNext = ST_DELAY;
                     cntNext   = CNT_W'(bus.delay - DELAY_W'(1));
                  end else begin
                     stateNext = ST_PULSE;
                     cntNext   = CNT_W'(widthM1In);
                  end
               end
            end
            ST_DELAY: begin
               if (cntReg == '0) begin
                  stateNext = ST_PULSE;
                  cntNext   = CNT_W'(widthM1Reg);
               end else begin
                  cntNext = cntReg - CNT_W'(1);
               end
            end
            ST_PULSE: begin
               if (cntReg == '0) begin
                  stateNext = ST_HOLDOFF;
                  cntNext   = CNT_W'(HOLDOFF - 1);
               end else begin
                  cntNext = cntReg - CNT_W'(1);
               end
            end
            ST_HOLDOFF: begin
               if (cntReg == '0) begin
                  stateNext = ST_IDLE;
                  doneNext  = 1'b1;
               end else begin
                  cntNext = cntReg - CNT_W'(1);
               end
            end
            default: begin
               stateNext = ST_IDLE;
               cntNext   = '0;
            end
         endcase
      end

      // Strobes are registered copies of "next state is PULSE" for the latched type.
      pulseNext     = (stateNext == ST_PULSE);
      calStrobeNext = (pulseNext && isCalNext) ? ~calIdleLevel : calIdleLevel;
      dtpStrobeNext = pulseNext && !isCalNext;

      missSum    = {1'b0, missedReg} + {3'b000, missInc};
      missedNext = missSum[4] ? 4'hF : missSum[3:0];
   end

   always_ff @(posedge bclka) begin
      if (!rstb) begin
         stateReg     <= ST_IDLE;
         cntReg       <= '0;
         isCalReg     <= 1'b0;
         widthM1Reg   <= '0;
         reqDReg      <= 2'b00;
         calStrobeReg <= calIdleLevel;
         dtpStrobeReg <= 1'b0;
         doneReg      <= 1'b0;
         missedReg    <= 4'd0;
      end else begin
         stateReg     <= stateNext;
         cntReg       <= cntNext;
         isCalReg     <= isCalNext;
         widthM1Reg   <= widthM1Next;
         reqDReg      <= reqVec;
         calStrobeReg <= calStrobeNext;
         dtpStrobeReg <= dtpStrobeNext;
         doneReg      <= doneNext;
         missedReg    <= missedNext;
      end
   end

   assign bus.calStrobe = calStrobeReg;
   assign bus.dtpStrobe = dtpStrobeReg;
   assign bus.busy      = (stateReg != ST_IDLE);
   assign bus.done      = doneReg;
   assign bus.missed    = missedReg;
endmodule

// File: doc/cal_strobe_seq.md
# cal_strobe_seq

Calibration/digital-test strobe sequencer sitting directly downstream of the special-command register. It turns the register's calibration-pulse and digital-test-pulse requests into a single precisely placed strobe. The strobe has a programmable BC delay and width, and a hold-off window that blocks retriggering. Requests that arrive while busy are counted, not queued.

## Interface
- DELAY_W, 6: width of delay setting; delay range 0..2^DELAY_W-1 BC.
- WIDTH_W, 4: width of strobe-width setting.
- HOLDOFF, 4: fixed hold-off length in BC after each strobe (>=1).
- bclka  in  1  clock; all state on posedge.
- rstb  in  1  reset; synchronous, active-low.
- calReq  in  1  calibration request level from the special-command register (8-BC high pulse).
- dtpReq  in  1  digital test request level (1-BC pulse).
- enable  in  1  sequencer enable; 0 forces IDLE and deasserts strobes on the next edge.
- delay  in  DELAY_W  strobe delay in BC, sampled at request acceptance.
- width  in  WIDTH_W  strobe width in BC, sampled at acceptance; 0 is treated as 1.
- calPolarity  in  1  strobe polarity select (see Configuration).
- calStrobe  out  1  analog calibration strobe.
- dtpStrobe  out  1  digital test strobe.
- busy  out  1  high in any state other than IDLE.
- done  out  1  1-BC pulse on the HOLDOFF->IDLE transition.
- missed  out  4  saturating count of rejected requests.

## Operation
- Rising-edge detect on calReq and dtpReq using a registered previous value. calReqD and dtpReqD reset to 0, so a request already high at reset release counts as a rise.
- FSM states: IDLE, DELAY, PULSE, HOLDOFF. Encoding is free.
- IDLE, on a rise and enable=1:
  - Latch type (cal or dtp), delay and width.
  - If delay>0: go to DELAY with cnt=delay-1.
  - If delay=0: go to PULSE with cnt=max(width,1)-1 and assert the selected strobe.
- DELAY: decrement cnt each BC. At cnt=0, go to PULSE, assert the selected strobe, cnt=max(width,1)-1.
- PULSE: the selected strobe stays asserted. At cnt=0, deassert it, go to HOLDOFF with cnt=HOLDOFF-1. Otherwise decrement.
- HOLDOFF: decrement. At cnt=0, go to IDLE and pulse done.
- Simultaneous cal and dtp rises in IDLE: cal is accepted and dtp increments missed (+1).
- Any rise while not IDLE (including the edge that leaves HOLDOFF) increments missed. Two rises on the same edge while busy count +2. missed saturates at 15 and clears only on reset.
- enable=0 in any state: next edge goes to IDLE, strobes go inactive, no done pulse, missed unchanged. Rises while enable=0 are ignored, not counted.
- Reset values: state IDLE, cnt 0, calStrobe at its inactive level (0 with default polarity), dtpStrobe 0, busy 0, done 0, missed 0.
- Reset asserted mid-sequence: all of the above apply on the same edge.

## Timing
- All outputs are registered. busy is decoded from registered state.
- A request rise is seen at edge N, with delay D and width W (W'=max(W,1)):
  - the strobe becomes active after edge N+D;
  - the strobe becomes inactive after edge N+D+W';
  - done is high for the cycle after edge N+D+W'+HOLDOFF;
  - the earliest next accepted rise is at edge N+D+W'+HOLDOFF+1.
- busy is high from after edge N through after edge N+D+W'+HOLDOFF-1.
- delay and width changes after acceptance do not affect the running sequence.

## Configuration
- CAL_POLARITY_EN defined: calPolarity=1 makes calStrobe active-high. calPolarity=0 makes it active-low (idle 1, reset value 1).
- CAL_POLARITY_EN undefined: calPolarity is ignored and calStrobe is always active-high (reset 0).
- dtpStrobe is always active-high in both builds.

## Test plan
- Reset, enable=1, delay=3, width=2, calReq high 8 BC starting at edge 10 -> calStrobe high after edges 13-14, low at 15; done high after edge 19; missed=0.
- delay=0, width=0, dtpReq 1-BC pulse at edge 5 -> dtpStrobe high for exactly 1 BC after edge 5; calStrobe never active.
- calReq and dtpReq rise on the same edge -> calStrobe sequence only, missed=1.
- Second calReq rise during DELAY, and another on the HOLDOFF exit edge -> both rejected, missed=2; 20 more busy-time rises -> missed saturates at 15.
- enable dropped mid-PULSE -> strobe inactive and busy=0 after the next edge, no done pulse; rstb low mid-DELAY gives the same result plus missed=0.
- With CAL_POLARITY_EN and calPolarity=0 -> calStrobe idles at 1 (including reset) and goes low for W' BC. Without the macro, the same stimulus gives an active-high strobe.
